sample_packer: RTL and testbench
================================

Name: sample_packer

Overview:
- Front end of the adder-tree datapath: gathers a serial stream of 14-bit samples, one per handshake, into an 8-lane operand vector.
- The vector feeds the first reduction stage directly: lane 0 drives inA, lane 1 drives inB, and so on through lane 7 to inH.
- Valid/ready on both sides. A short frame is closed early with InLast and zero-padded, so the adder sums are unaffected by the padding.

Parameters:
- DATA_W, 14, sample and lane width.
- LANES, 8, lanes per output beat; must be a power of two and at least 2.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- InData  in  DATA_W  sample.
- InValid  in  1  sample present.
- InLast  in  1  final sample of the frame; qualified by InValid.
- InReady  out  1  packer accepts InData this cycle.
- Flush  in  1  synchronous discard of the partial beat.
- OutLanes  out  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]; lane 0 holds the oldest sample.
- OutCount  out  $clog2(LANES)+1  number of real lanes in the beat, 1..LANES.
- OutValid  out  1  beat present.
- OutReady  in  1  sink takes the beat.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - OutValid=0, OutLanes=0, OutCount=0;
  - lane index idx=0;
  - fill buffer all zero;
  - state=EMPTY.
- Handshakes:
  - Input accept = InValid && InReady.
  - Output transfer = OutValid && OutReady.
  - InReady = !Flush && (!OutValid || OutReady), combinational.
  - Full rate is sustained when OutReady is held high.
- State machine:
  - EMPTY (idx=0): on accept, write fill[0] and go to FILLING with idx=1, unless the accept emits a beat.
  - FILLING: on accept, write fill[idx] and increment idx.
  - Emission condition: accept with InLast=1 or idx==LANES-1.
- Emission, on the same edge as the accept:
  - OutLanes gets fill[0..idx-1] in lanes 0..idx-1, InData in lane idx, and zero in lanes above idx.
  - OutCount=idx+1 and OutValid=1.
  - The fill buffer is cleared, idx=0, and the state returns to EMPTY.
- Latency: one cycle from the accept of the final sample to OutValid.
- OutValid, OutLanes and OutCount are registered and stay stable while OutValid && !OutReady.
- Transfer with no emission: OutValid goes to 0. OutLanes and OutCount keep their stale values.
- Transfer and emission on the same edge: the new beat replaces the old one and OutValid stays 1 (no bubble).
- Flush=1:
  - idx=0, fill buffer cleared, state=EMPTY on the next edge.
  - InReady=0, so no sample is lost silently.
  - The output register is untouched; a pending beat is still delivered.
- InLast on the very first sample of a frame: emits a 1-lane beat with OutCount=1.
- InLast on lane LANES-1: a normal full beat with OutCount=LANES.
- No arithmetic is done here; samples pass through bit-exact.
- Reset asserted mid-frame: all partial data is discarded immediately, without waiting for a clock edge.

Optional Feature:
- Macro: SAMPLE_PACKER_BEAT_CNT_EN.
- Defined: adds output BeatCount [15:0].
  - Reset to 0.
  - Increments once per output transfer.
  - Saturates at 16'hFFFF.
  - Not cleared by Flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - DATA_W and LANES defaults;
  - IDX_W=$clog2(LANES);
  - the state enum {EMPTY, FILLING};
  - a lane-slice helper function giving the offset k*DATA_W.
- The same package constants serve the adder-tree stages downstream.
- No sub-module; a single always_ff block plus a combinational InReady is natural.

Test Plan:
- Full beat: 8 samples 1..8 with OutReady=1 -> one beat, OutLanes lanes 0..7 = 1..8, OutCount=8, OutValid high for exactly 1 cycle.
- Short frame: samples 5, 6, 7 with InLast on 7 -> lanes = {7,6,5 in lanes 2,1,0; zero in lanes 3..7}, OutCount=3.
- Backpressure:
  - 8 samples are accepted with OutReady=0.
  - InReady must then drop and the beat must be held stable for 10 cycles.
  - OutReady=1 -> transfer; InReady rises in that same cycle.
- Back-to-back with OutReady=1: 16 consecutive samples (InValid held high, 0x3FFF down to 0x3FF0) -> 2 beats, no bubble, no sample drop.
- Flush after 3 samples, then 8 new samples 9..16 -> the beat holds only 9..16. Then Reset pulsed mid-frame -> OutValid=0 and idx=0 immediately, without a clock edge.
- With SAMPLE_PACKER_BEAT_CNT_EN: 3 transfers -> BeatCount=3.

Source files
------------

// File: rtl/sample_packer_pkg.sv
// Shared constants, state encoding and lane-slice helper for the adder-tree front end.
// The same constants size the downstream reduction stages.
package sample_packer_pkg;

  localparam int DATA_W = 14;
  localparam int LANES  = 8;
  localparam int IDX_W  = $clog2(LANES);

  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } state_t;

  // Bit offset of lane k inside a packed lane vector of w-bit lanes.
  function automatic int lane_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sample_packer.sv
// Packs a serial sample stream into LANES-wide, zero-padded operand beats for the adder tree.
// Optional beat counter output enabled by SAMPLE_PACKER_BEAT_CNT_EN.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int DATA_W = sample_packer_pkg::DATA_W,
  parameter int LANES  = sample_packer_pkg::LANES
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [DATA_W-1:0]         InData,
  input  logic                      InValid,
  input  logic                      InLast,
  output logic                      InReady,
  input  logic                      Flush,
  output logic [LANES*DATA_W-1:0]   OutLanes,
  output logic [$clog2(LANES):0]    OutCount,
  output logic                      OutValid,
  input  logic                      OutReady
`ifdef SAMPLE_PACKER_BEAT_CNT_EN
  ,
  output logic [15:0]               BeatCount
`endif
);

  localparam int CNT_W = $clog2(LANES) + 1;

  state_t                    state_r, state_nx;
  logic [CNT_W-2:0]          idx_r, idx_nx;
  logic [DATA_W-1:0]         fill_r [LANES];
  logic [LANES*DATA_W-1:0]   lanes_r, beat_s;
  logic [CNT_W-1:0]          count_r;
  logic                      valid_r;
  logic                      accept_s, emit_s, xfer_s, at_end_s;

  assign InReady  = !Flush && (!valid_r || OutReady);
  assign accept_s = InValid && InReady;
  assign at_end_s = (idx_r == (CNT_W-1)'(LANES-1));
  assign emit_s   = accept_s && (InLast || at_end_s);
  assign xfer_s   = valid_r && OutReady;

  // Next state and lane index; an emitting accept always returns to EMPTY.
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    if (Flush) begin
      state_nx = EMPTY;
      idx_nx   = '0;
    end else begin
      case (state_r)
        EMPTY, FILLING: begin
          if (emit_s) begin
            state_nx = EMPTY;
            idx_nx   = '0;
          end else if (accept_s) begin
            state_nx = FILLING;
            idx_nx   = idx_r + (CNT_W-1)'(1);
          end else begin
            state_nx = state_r;
            idx_nx   = idx_r;
          end
        end
        default: begin
          state_nx = EMPTY;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Candidate beat: buffered lanes below idx, the incoming sample at idx, zeros above.
  always_comb begin
    beat_s = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(idx_r)) begin
        beat_s[lane_off(k, DATA_W) +: DATA_W] = fill_r[k];
      end else if (k == int'(idx_r)) begin
        beat_s[lane_off(k, DATA_W) +: DATA_W] = InData;
      end else begin
        beat_s[lane_off(k, DATA_W) +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  // Fill buffer, FSM state and the registered output beat.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= EMPTY;
      idx_r   <= '0;
      lanes_r <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        fill_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
      if (Flush || emit_s) begin
        for (int k = 0; k < LANES; k++) begin
          fill_r[k] <= {DATA_W{1'b0}};
        end
      end else if (accept_s) begin
        fill_r[idx_r] <= InData;
      end
      // A new beat overwrites one leaving on the same edge, so no bubble appears.
      if (emit_s) begin
        lanes_r <= beat_s;
        count_r <= {1'b0, idx_r} + CNT_W'(1);
        valid_r <= 1'b1;
      end else if (xfer_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign OutLanes = lanes_r;
  assign OutCount = count_r;
  assign OutValid = valid_r;

`ifdef SAMPLE_PACKER_BEAT_CNT_EN
  logic [15:0] beat_cnt_r;

  // Saturating count of delivered beats; Flush leaves it alone.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      beat_cnt_r <= 16'h0000;
    end else if (xfer_s && (beat_cnt_r != 16'hFFFF)) begin
      beat_cnt_r <= beat_cnt_r + 16'h0001;
    end
  end

  assign BeatCount = beat_cnt_r;
`endif

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: frame table plus hand-written corner sequences,
// with a sample-level model feeding a queue of expected beats.
module tb_sample_packer;

  typedef struct {
    logic [111:0] lanes;
    logic [3:0]   count;
  } beat_t;

  typedef struct {
    int          n;
    logic [13:0] first;
    int          step;
    logic        last_end;
    logic [3:0]  exp_count;
  } frame_t;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [13:0]   InData;
  logic          InValid;
  logic          InLast;
  logic          InReady;
  logic          Flush;
  logic [111:0]  OutLanes;
  logic [3:0]    OutCount;
  logic          OutValid;
  logic          OutReady;
`ifdef SAMPLE_PACKER_BEAT_CNT_EN
  logic [15:0]   BeatCount;
`endif

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          xfers = 0;
  logic [3:0]  last_cnt = 4'd0;
  beat_t       exp_q[$];
  logic [13:0] mbuf[$];
  frame_t      tbl[5];

  sample_packer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .InData   (InData),
    .InValid  (InValid),
    .InLast   (InLast),
    .InReady  (InReady),
    .Flush    (Flush),
    .OutLanes (OutLanes),
    .OutCount (OutCount),
    .OutValid (OutValid),
    .OutReady (OutReady)
`ifdef SAMPLE_PACKER_BEAT_CNT_EN
    ,
    .BeatCount(BeatCount)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_push(input logic [13:0] d, input logic l);
    beat_t b;
    mbuf.push_back(d);
    if (l || mbuf.size() == 8) begin
      b.lanes = '0;
      for (int k = 0; k < mbuf.size(); k++) b.lanes[k*14 +: 14] = mbuf[k];
      b.count = 4'(mbuf.size());
      exp_q.push_back(b);
      mbuf.delete();
    end
  endfunction

  // Scoreboard: every transfer must match the oldest expected beat.
  always @(negedge Clk) begin
    if (!Reset && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got lanes %0h count %0d, none expected", OutLanes, OutCount);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_lanes", OutLanes, b.lanes);
        check("beat_count", OutCount, b.count);
        last_cnt = OutCount;
        xfers++;
      end
    end
  end

  task automatic send(input logic [13:0] d, input logic l);
    InData  = d;
    InLast  = l;
    InValid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge Clk);
      if (InReady) begin
        model_push(d, l);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        InLast  = 1'b0;
        return;
      end
      @(posedge Clk);
      #1;
    end
    check("send_timeout", 1'b1, 1'b0);
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge Clk);
      #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; InData = 14'd0; InValid = 1'b0; InLast = 1'b0;
    Flush = 1'b0; OutReady = 1'b1;
    #1;
    check("rst_valid", OutValid, 1'b0);
    check("rst_lanes", OutLanes, 112'd0);
    check("rst_count", OutCount, 4'd0);
    check("rst_inready", InReady, 1'b1);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    tbl[0] = '{8, 14'd1,      1, 1'b0, 4'd8};
    tbl[1] = '{3, 14'd5,      1, 1'b1, 4'd3};
    tbl[2] = '{1, 14'h2AAA,   1, 1'b1, 4'd1};
    tbl[3] = '{8, 14'h0100,   3, 1'b1, 4'd8};
    tbl[4] = '{5, 14'h3FFF,  -1, 1'b1, 4'd5};
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < tbl[f].n; i++) begin
        send(14'(int'(tbl[f].first) + i * tbl[f].step), tbl[f].last_end && (i == tbl[f].n - 1));
      end
      @(negedge Clk);
      check("frame_valid_hi", OutValid, 1'b1);
      @(negedge Clk);
      check("frame_valid_lo", OutValid, 1'b0);
      check("frame_count", last_cnt, tbl[f].exp_count);
      check("frame_q_empty", exp_q.size(), 0);
      @(posedge Clk);
      #1;
    end

    // Backpressure: beat held while the sink stalls, InReady returns with OutReady.
    OutReady = 1'b0;
    for (int i = 0; i < 8; i++) send(14'h1000 + 14'(i), 1'b0);
    @(negedge Clk);
    check("bp_inready_lo", InReady, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      check("bp_hold_valid", OutValid, 1'b1);
      if (exp_q.size() == 1) check("bp_hold_lanes", OutLanes, exp_q[0].lanes);
      else check("bp_q_size", exp_q.size(), 1);
    end
    @(posedge Clk);
    #1;
    OutReady = 1'b1;
    #1;
    check("bp_inready_hi", InReady, 1'b1);
    drain();

    // Back-to-back: 16 samples in 16 cycles, two beats.
    begin
      int start;
      start = cyc;
      for (int i = 0; i < 16; i++) send(14'h3FFF - 14'(i), 1'b0);
      check("b2b_cycles", cyc - start, 16);
      drain();
    end

    // Flush discards the partial beat.
    for (int i = 0; i < 3; i++) send(14'd100 + 14'(i), 1'b0);
    Flush = 1'b1;
    #1;
    check("flush_inready", InReady, 1'b0);
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    mbuf.delete();
    for (int i = 0; i < 8; i++) send(14'd9 + 14'(i), 1'b0);
    drain();

    // Asynchronous reset mid-frame with stale output contents.
    send(14'h0055, 1'b0);
    send(14'h0066, 1'b1);
    for (int i = 0; i < 3; i++) send(14'h0011 + 14'(i), 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check("arst_valid", OutValid, 1'b0);
    check("arst_count", OutCount, 4'd0);
    check("arst_lanes", OutLanes, 112'd0);
    mbuf.delete();
    exp_q.delete();
    xfers = 0;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 8; i++) send(14'h0200 + 14'(i), 1'b0);
    send(14'h0333, 1'b1);
    send(14'h0444, 1'b1);
    drain();
    check("post_rst_xfers", xfers, 3);
`ifdef SAMPLE_PACKER_BEAT_CNT_EN
    check("beat_count_out", BeatCount, 16'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
